mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: SKIP_HI, default 1; when 1, op MUL skips the a_hi*b_hi partial product, which cannot affect the low 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  requester presents an operation.
REQ-005 req_ready  out  1  controller can accept; high only in IDLE.
REQ-006 req_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS (high 32 of the product).
REQ-007 req_a  in  32  operand a.
REQ-008 req_b  in  32  operand b.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  consumer takes result.
REQ-011 res_data  out  32  result word.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 mul_a  out  16  operand to the external registered 16x16 unsigned multiplier.
REQ-014 mul_b  out  16  operand to the external registered 16x16 unsigned multiplier.
REQ-015 mul_en  out  1  multiplier register enable.
REQ-016 mul_p  in  32  multiplier product; valid the cycle after the issue cycle with mul_en=1.

Function
REQ-017 States: IDLE, ISSUE, DRAIN, FIX, DONE; 2-bit issue index k.
REQ-018 Accept occurs on a req_valid & req_ready edge: latch a, b and op; clear the 64-bit accumulator; k=0; go to ISSUE. Request inputs are ignored after accept.
REQ-019 ISSUE, mul_en=1, issue order:
- k0: a[15:0]*b[15:0], shift 0
- k1: a[15:0]*b[31:16], shift 16
- k2: a[31:16]*b[15:0], shift 16
- k3: a[31:16]*b[31:16], shift 32
REQ-020 ISSUE exits to DRAIN after k3, or after k2 when op=MUL and SKIP_HI=1.
REQ-021 In each cycle following an issue, the accumulator adds mul_p zero-extended and shifted per its k, modulo 2^64. The last add occurs in DRAIN.
REQ-022 mul_en is 0 in IDLE, DRAIN, FIX and DONE. In those states mul_a and mul_b hold their last value.
REQ-023 DRAIN goes to FIX for MULX* ops and to DONE for MUL.
REQ-024 FIX applies one signed correction to acc[63:32]:
- subtract b when op is MULXSU/MULXSS and a[31]=1;
- subtract a when op is MULXSS and b[31]=1;
- both subtractions modulo 2^32.
REQ-025 DONE drives res_valid=1, with res_data = acc[31:0] for MUL and acc[63:32] otherwise. res_data is held stable until res_ready.
REQ-026 DONE with res_ready=1 returns to IDLE. req_ready is high the next cycle, so back-to-back accept is not possible in the same cycle as the result handshake.
REQ-027 Latency from the accept edge (cycle 0) to the first res_valid cycle:
- MULX*: 7
- MUL, SKIP_HI=1: 5
- MUL, SKIP_HI=0: 6
REQ-028 req_valid while busy is ignored and not queued. The req_ready/req_valid handshake must not depend combinationally on res_ready.
REQ-029 res_valid never rises outside DONE. Exactly one result is produced per accepted request.

Reset
REQ-030 With reset high at an edge, the next cycle shows:
- state IDLE
- res_valid 0, res_data 0
- mul_en 0, mul_a 0, mul_b 0
- accumulator 0, busy 0
- req_ready 1 once reset deasserts
REQ-031 Reset in any state, including mid-ISSUE, aborts the operation with no result emitted. req_valid is ignored while reset is high.

Verification
REQ-032 MUL a=0x00000003, b=0x00000005, SKIP_HI=1 -> res_data 0x0000000F; res_valid first high in cycle 5; mul_en high in cycles 1-3 only.
REQ-033 MULXUU a=b=0xFFFFFFFF -> res_data 0xFFFFFFFE in cycle 7.
REQ-034 MULXSU a=0xFFFFFFFF, b=0xFFFFFFFF -> res_data 0xFFFFFFFF. MULXSS a=0x80000000, b=0x80000000 -> res_data 0x40000000.
REQ-035 Backpressure: hold res_ready=0 for 10 cycles after res_valid while pulsing req_valid -> res_valid and res_data stay stable, req_ready stays 0, and no extra result appears.
REQ-036 Reset asserted in the 2nd ISSUE cycle -> next cycle IDLE with mul_en=0 and no res_valid; then MUL 7*6 -> res_data 0x0000002A.
REQ-037 Back-to-back: two MULXSS requests with req_valid held high (-1*2, then 3*-4) -> res_data 0xFFFFFFFF for both. The second accept occurs one cycle after the first result handshake.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 multiply controller driving an external registered 16x16
// unsigned multiplier; produces the low or high product word with signed fix-up.
module mul_seq_ctrl #(
    parameter bit SKIP_HI = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        busy_o,
    output logic [15:0] mul_a_o,
    output logic [15:0] mul_b_o,
    output logic        mul_en_o,
    input  logic [31:0] mul_p_i,
    output logic [2:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; req_ready depends only on state, never on res_ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_k_q, pend_k_d;
    logic [15:0] mul_a_q, mul_a_d;
    logic [15:0] mul_b_q, mul_b_d;
    logic [31:0] res_q, res_d;

    logic [63:0] addend;
    logic [63:0] acc_sum;
    logic [31:0] fix_hi;
    logic [1:0]  k_next;
    logic        last_issue;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            k_q      <= 2'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            pend_q   <= 1'b0;
            pend_k_q <= 2'd0;
            mul_a_q  <= 16'd0;
            mul_b_q  <= 16'd0;
            res_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            pend_q   <= pend_d;
            pend_k_q <= pend_k_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        pend_d   = pend_q;
        pend_k_d = pend_k_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        res_d    = res_q;

        // The product returning this cycle belongs to the issue index recorded last cycle.
        case (pend_k_q)
            2'd0:    addend = {32'd0, mul_p_i};
            2'd3:    addend = {mul_p_i, 32'd0};
            default: addend = {16'd0, mul_p_i, 16'd0};
        endcase
        acc_sum = acc_q + addend;

        fix_hi = acc_q[63:32];
        if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31]) fix_hi = fix_hi - b_q;
        if (op_q == OP_MULXSS && b_q[31]) fix_hi = fix_hi - a_q;

        k_next     = k_q + 2'd1;
        last_issue = (k_q == 2'd3) || (k_q == 2'd2 && op_q == OP_MUL && SKIP_HI);

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    a_d      = req_a_i;
                    b_d      = req_b_i;
                    op_d     = req_op_i;
                    acc_d    = 64'd0;
                    k_d      = 2'd0;
                    pend_d   = 1'b0;
                    mul_a_d  = req_a_i[15:0];
                    mul_b_d  = req_b_i[15:0];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pend_q) acc_d = acc_sum;
                pend_d   = 1'b1;
                pend_k_d = k_q;
                if (last_issue) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d     = k_next;
                    mul_a_d = k_next[1] ? a_q[31:16] : a_q[15:0];
                    mul_b_d = k_next[0] ? b_q[31:16] : b_q[15:0];
                end
            end
            S_DRAIN: begin
                acc_d  = acc_sum;
                pend_d = 1'b0;
                if (op_q == OP_MUL) begin
                    res_d   = acc_sum[31:0];
                    state_d = S_DONE;
                end else begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                acc_d   = {fix_hi, acc_q[31:0]};
                res_d   = fix_hi;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = (state_q == S_DONE);
    assign res_data_o  = res_q;
    assign mul_en_o    = (state_q == S_ISSUE);
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural registered 16x16 multiplier.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p = 32'd0;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  mul_seq_ctrl #(.SKIP_HI(1'b1)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_en_o(mul_en),
    .mul_p_i(mul_p), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // external registered unsigned 16x16 multiplier
  always_ff @(posedge clk) begin
    if (mul_en) mul_p <= 32'(mul_a) * 32'(mul_b);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a request at the current negedge; the following posedge is the accept edge.
  // Waits for res_valid, checks latency, mul_en cycle count and data from exp_q.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold_valid, input logic [31:0] nxt_a, input logic [31:0] nxt_b);
    int cyc;
    int en_cnt;
    logic [31:0] e;
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    exp_q.push_back(exp);
    check({name, " ready_at_req"}, 64'(req_ready), 64'd1);
    cyc = 0;
    en_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1) begin
        if (hold_valid) begin
          req_a = nxt_a;
          req_b = nxt_b;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (mul_en) en_cnt++;
      if (res_valid) break;
    end
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " mul_en_cycles"}, 64'(en_cnt), (op == 2'b00) ? 64'd3 : 64'd4);
    e = exp_q.pop_front();
    check({name, " res_data"}, 64'(res_data), 64'(e));
  endtask

  task automatic take_result(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " res_valid_after_take"}, 64'(res_valid), 64'd0);
    check({name, " req_ready_after_take"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] held;
    vecs[0]  = '{2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 5};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7};
    vecs[3]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7};
    vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5};
    vecs[5]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 5};
    vecs[6]  = '{2'b00, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 5};
    vecs[7]  = '{2'b00, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 5};
    vecs[8]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7};
    vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7};
    vecs[10] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 7};
    vecs[11] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 7};

    // reset state
    repeat (2) @(negedge clk);
    check("rst state", 64'(dbg_state), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst res_data", 64'(res_data), 64'd0);
    check("rst mul_en", 64'(mul_en), 64'd0);
    check("rst mul_a", 64'(mul_a), 64'd0);
    check("rst mul_b", 64'(mul_b), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst req_ready", 64'(req_ready), 64'd1);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, 1'b0, 32'd0, 32'd0);
      take_result($sformatf("vec%0d", i));
    end

    // backpressure with req_valid pulses while the result waits
    run_op("bp", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7, 1'b0, 32'd0, 32'd0);
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      req_op = 2'b00;
      req_a = 32'd9;
      req_b = 32'd9;
      @(negedge clk);
      check("bp res_valid", 64'(res_valid), 64'd1);
      check("bp res_data", 64'(res_data), 64'(held));
      check("bp req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    take_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp no_extra", 64'(res_valid), 64'd0);
    end

    // reset in the second ISSUE cycle
    req_op = 2'b11;
    req_a = 32'h1234_5678;
    req_b = 32'h8765_4321;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmid issue1", 64'(dbg_state), 64'd1);
    @(negedge clk);
    check("rmid issue2", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    check("rmid state", 64'(dbg_state), 64'd0);
    check("rmid mul_en", 64'(mul_en), 64'd0);
    check("rmid res_valid", 64'(res_valid), 64'd0);
    check("rmid busy_in_reset", 64'(busy), 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rmid no_result", 64'(res_valid), 64'd0);
    end
    run_op("rmid_mul", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 5, 1'b0, 32'd0, 32'd0);
    take_result("rmid_mul");

    // back-to-back with req_valid held high
    run_op("b2b_1", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 7,
           1'b1, 32'h0000_0003, 32'hFFFF_FFFC);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b res_valid_after_take", 64'(res_valid), 64'd0);
    check("b2b req_ready_gap", 64'(req_ready), 64'd1);
    run_op("b2b_2", 2'b11, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 7,
           1'b0, 32'd0, 32'd0);
    take_result("b2b_2");

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
